// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM/owner types and default bus widths for the data-memory arbiter
package dmem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  typedef enum logic {OWN_P, OWN_D} owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: pipeline (p_*), debug (d_*) and memory (mem_*) buses around the arbiter
// slave modport is the arbiter side; master is the requesters-plus-memory side
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              p_read, p_write, p_done, p_stall;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata, p_rdata;
  logic              d_req, d_we, d_done;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write;
  modport slave (
    input  p_read, p_write, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output p_rdata, p_done, p_stall, d_rdata, d_done, mem_addr, mem_wdata, mem_read, mem_write
  );
  modport master (
    output p_read, p_write, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  p_rdata, p_done, p_stall, d_rdata, d_done, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: saturating count of pipeline grants taken while debug waits
// ports: clk, rst (async, active-low), inc, clr (wins over inc), full (count == MAX)
module dmem_starve_ctr
  import dmem_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic full
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] cnt;
  assign full = cnt == W'(MAX);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !full) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the pipeline MEM stage and a debug port
// ports: clk, rst (async, active-low), bus (dmem_arbiter_if.slave: p_* pipeline, d_* debug, mem_* memory)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  state_t            state, state_n;
  owner_t            owner;
  logic [LW-1:0]     lat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q, p_req, full, grant_p, grant_d, busy, last;
  assign p_req   = bus.p_read | bus.p_write;
  // pipeline wins ties unless debug has been passed over STARVE_MAX times
  assign grant_d = state == IDLE && bus.d_req && (!p_req || full);
  assign grant_p = state == IDLE && p_req && !grant_d;
  assign busy    = state == BUSY;
  assign last    = busy && lat_cnt == '0;
  dmem_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk,
    .rst,
    .inc(grant_p && bus.d_req),
    .clr(grant_d || !bus.d_req),
    .full
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n       = (grant_p || grant_d) ? BUSY : last ? GAP : state == GAP ? IDLE : state;
    bus.mem_addr  = busy ? addr_q : '0;
    bus.mem_wdata = busy ? wdata_q : '0;
    bus.mem_read  = busy && !we_q;
    // write strobe only on the first busy cycle, when the counter still holds its load value
    bus.mem_write = busy && we_q && lat_cnt == LW'(MEM_LAT - 1);
    bus.p_stall   = p_req && !bus.p_done;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner       <= OWN_P;
      lat_cnt     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      bus.p_done  <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.p_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      if (grant_p || grant_d) begin
        owner   <= grant_d ? OWN_D : OWN_P;
        addr_q  <= grant_d ? bus.d_addr : bus.p_addr;
        wdata_q <= grant_d ? bus.d_wdata : bus.p_wdata;
        we_q    <= grant_d ? bus.d_we : bus.p_write;
        lat_cnt <= LW'(MEM_LAT - 1);
      end else if (busy && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
      bus.p_done <= last && owner == OWN_P;
      bus.d_done <= last && owner == OWN_D;
      if (last && !we_q && owner == OWN_P) bus.p_rdata <= bus.mem_rdata;
      if (last && !we_q && owner == OWN_D) bus.d_rdata <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for the arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_dmem_arbiter;
  import dmem_pkg::*;
  typedef struct packed {
    logic        rn, pr, pw;
    logic [31:0] pa, pwd;
    logic        dq, dwe;
    logic [31:0] da, dwd, mrd;
  } in_t;
  typedef struct packed {
    logic        mr, mw;
    logic [31:0] ma, mwd;
    logic        pd, ps, dd;
    logic [31:0] prd, drd;
  } out_t;
  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;
  localparam logic [31:0] DB = 32'hDEADBEEF, A5 = 32'hA5A5A5A5, CF = 32'hCAFEF00D;
  logic clk, rst;
  int vectors = 0, miscompares = 0;
  vec_t vq[$];
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) d1 (.clk(clk), .rst(rst), .bus(b1));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) d3 (.clk(clk), .rst(rst), .bus(b3));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic in_t vin(logic pr, logic pw, logic [31:0] pa, logic [31:0] pwd, logic dq, logic dwe,
                              logic [31:0] da, logic [31:0] dwd, logic [31:0] mrd);
    return '{1'b1, pr, pw, pa, pwd, dq, dwe, da, dwd, mrd};
  endfunction
  function automatic out_t vout(logic mr, logic mw, logic [31:0] ma, logic [31:0] mwd, logic pd, logic ps,
                                logic dd, logic [31:0] prd, logic [31:0] drd);
    return '{mr, mw, ma, mwd, pd, ps, dd, prd, drd};
  endfunction
  function automatic out_t act1();
    return '{b1.mem_read, b1.mem_write, b1.mem_addr, b1.mem_wdata, b1.p_done, b1.p_stall, b1.d_done, b1.p_rdata, b1.d_rdata};
  endfunction
  function automatic out_t act3();
    return '{b3.mem_read, b3.mem_write, b3.mem_addr, b3.mem_wdata, b3.p_done, b3.p_stall, b3.d_done, b3.p_rdata, b3.d_rdata};
  endfunction
  task automatic add(input in_t i, input out_t o);
    vq.push_back('{i, o});
  endtask
  // one cycle: drive at the falling edge, compare 1 ns later
  task automatic apply(input bit sel, input in_t i, input out_t e, input string nm);
    out_t a;
    @(negedge clk);
    rst = i.rn;
    if (sel) begin
      b3.p_read = i.pr; b3.p_write = i.pw; b3.p_addr = i.pa; b3.p_wdata = i.pwd;
      b3.d_req = i.dq; b3.d_we = i.dwe; b3.d_addr = i.da; b3.d_wdata = i.dwd; b3.mem_rdata = i.mrd;
    end else begin
      b1.p_read = i.pr; b1.p_write = i.pw; b1.p_addr = i.pa; b1.p_wdata = i.pwd;
      b1.d_req = i.dq; b1.d_we = i.dwe; b1.d_addr = i.da; b1.d_wdata = i.dwd; b1.mem_rdata = i.mrd;
    end
    #1;
    a = sel ? act3() : act1();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got mr=%b mw=%b ma=%h mwd=%h pd=%b ps=%b dd=%b prd=%h drd=%h want mr=%b mw=%b ma=%h mwd=%h pd=%b ps=%b dd=%b prd=%h drd=%h",
               nm, a.mr, a.mw, a.ma, a.mwd, a.pd, a.ps, a.dd, a.prd, a.drd,
               e.mr, e.mw, e.ma, e.mwd, e.pd, e.ps, e.dd, e.prd, e.drd);
    end
  endtask
  initial begin
    in_t idle, t, cin, pin, both, sin, rin, rlo;
    rst = 1'b0;
    {b1.p_read, b1.p_write, b1.p_addr, b1.p_wdata, b1.d_req, b1.d_we, b1.d_addr, b1.d_wdata, b1.mem_rdata} = '0;
    {b3.p_read, b3.p_write, b3.p_addr, b3.p_wdata, b3.d_req, b3.d_we, b3.d_addr, b3.d_wdata, b3.mem_rdata} = '0;
    idle = vin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // during reset: everything cleared, stall tracks the raw request
    t = vin(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    t.rn = 1'b0;
    apply(0, t, vout(0, 0, 0, 0, 0, 1, 0, 0, 0), "rst_stall_follows_req");
    t = idle;
    t.rn = 1'b0;
    apply(0, t, vout(0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_all_zero");
    // pipeline load, MEM_LAT=1
    add(vin(1, 0, 32'h10, 0, 0, 0, 0, 0, 0),  vout(0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(vin(1, 0, 32'h10, 0, 0, 0, 0, 0, DB), vout(1, 0, 32'h10, 0, 0, 1, 0, 0, 0));
    add(vin(1, 0, 32'h10, 0, 0, 0, 0, 0, 0),  vout(0, 0, 0, 0, 1, 0, 0, DB, 0));
    add(idle,                                 vout(0, 0, 0, 0, 0, 0, 0, DB, 0));
    // debug read while pipeline idle
    add(vin(0, 0, 0, 0, 1, 0, 32'h40, 0, 0),  vout(0, 0, 0, 0, 0, 0, 0, DB, 0));
    add(vin(0, 0, 0, 0, 1, 0, 32'h40, 0, A5), vout(1, 0, 32'h40, 0, 0, 0, 0, DB, 0));
    add(vin(0, 0, 0, 0, 1, 0, 32'h40, 0, 0),  vout(0, 0, 0, 0, 0, 0, 1, DB, A5));
    add(idle,                                 vout(0, 0, 0, 0, 0, 0, 0, DB, A5));
    // read and write both high behaves as a write
    both = vin(1, 1, 32'h80, CF, 0, 0, 0, 0, 32'h11111111);
    add(both, vout(0, 0, 0, 0, 0, 1, 0, DB, A5));
    add(both, vout(0, 1, 32'h80, CF, 0, 1, 0, DB, A5));
    add(both, vout(0, 0, 0, 0, 1, 0, 0, DB, A5));
    add(idle, vout(0, 0, 0, 0, 0, 0, 0, DB, A5));
    // contention: four pipeline reads, then the starved debug write
    cin = vin(1, 0, 32'h100, 0, 1, 1, 32'h200, 32'h55, 32'h77);
    for (int k = 0; k < 4; k++) begin
      add(cin, vout(0, 0, 0, 0, 0, 1, 0, k == 0 ? DB : 32'h77, A5));
      add(cin, vout(1, 0, 32'h100, 0, 0, 1, 0, k == 0 ? DB : 32'h77, A5));
      add(cin, vout(0, 0, 0, 0, 1, 0, 0, 32'h77, A5));
    end
    add(cin, vout(0, 0, 0, 0, 0, 1, 0, 32'h77, A5));
    add(cin, vout(0, 1, 32'h200, 32'h55, 0, 1, 0, 32'h77, A5));
    add(cin, vout(0, 0, 0, 0, 0, 1, 1, 32'h77, A5));
    pin = vin(1, 0, 32'h100, 0, 0, 0, 0, 0, 32'h88);
    add(pin,  vout(0, 0, 0, 0, 0, 1, 0, 32'h77, A5));
    add(pin,  vout(1, 0, 32'h100, 0, 0, 1, 0, 32'h77, A5));
    add(pin,  vout(0, 0, 0, 0, 1, 0, 0, 32'h88, A5));
    add(idle, vout(0, 0, 0, 0, 0, 0, 0, 32'h88, A5));
    foreach (vq[n]) apply(0, vq[n].i, vq[n].o, $sformatf("vec%0d", n));
    // pipeline store, MEM_LAT=3
    sin = vin(0, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 32'hFFFFFFFF);
    apply(1, sin,  vout(0, 0, 0, 0, 0, 1, 0, 0, 0), "st_idle");
    apply(1, sin,  vout(0, 1, 32'h20, 32'h12345678, 0, 1, 0, 0, 0), "st_busy1");
    apply(1, sin,  vout(0, 0, 32'h20, 32'h12345678, 0, 1, 0, 0, 0), "st_busy2");
    apply(1, sin,  vout(0, 0, 32'h20, 32'h12345678, 0, 1, 0, 0, 0), "st_busy3");
    apply(1, sin,  vout(0, 0, 0, 0, 1, 0, 0, 0, 0), "st_done");
    apply(1, idle, vout(0, 0, 0, 0, 0, 0, 0, 0, 0), "st_after");
    // reset in the 2nd busy cycle of a MEM_LAT=3 read, then re-grant
    rin = vin(1, 0, 32'h30, 0, 0, 0, 0, 0, 32'h0BADF00D);
    rlo = rin;
    rlo.rn = 1'b0;
    apply(1, rin, vout(0, 0, 0, 0, 0, 1, 0, 0, 0), "rs_idle");
    apply(1, rin, vout(1, 0, 32'h30, 0, 0, 1, 0, 0, 0), "rs_busy1");
    apply(1, rlo, vout(0, 0, 0, 0, 0, 1, 0, 0, 0), "rs_async_clear");
    apply(1, rlo, vout(0, 0, 0, 0, 0, 1, 0, 0, 0), "rs_held");
    apply(1, rin, vout(0, 0, 0, 0, 0, 1, 0, 0, 0), "rs_release");
    for (int k = 0; k < 3; k++) apply(1, rin, vout(1, 0, 32'h30, 0, 0, 1, 0, 0, 0), $sformatf("rs_regrant%0d", k));
    apply(1, rin,  vout(0, 0, 0, 0, 1, 0, 0, 32'h0BADF00D, 0), "rs_done");
    apply(1, idle, vout(0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D, 0), "rs_after");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
